// File: rtl/osch_pkg.sv
// Shared constants and the phase-increment helper for the osch oscillator model.
package osch_pkg;

  localparam int DEF_ACC_W = 32;

  // round(nom * 2^acc_w / ref), evaluated at elaboration.
  function automatic logic [63:0] calc_inc(input longint unsigned ref_khz,
                                           input longint unsigned nom_khz,
                                           input int              acc_w);
    logic [63:0] num;
    num = (64'(nom_khz) << acc_w) + 64'(ref_khz / 2);
    return num / 64'(ref_khz);
  endfunction

endpackage

// File: rtl/osch_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/osch.sv
// Phase-accumulator stand-in for the on-chip oscillator, with startup delay,
// glitch-free standby, a rising-edge strobe and a run-status flag.
module osch
  import osch_pkg::*;
#(
  parameter int REF_FREQ_KHZ = 100000,
  parameter int NOM_FREQ_KHZ = 15650,
  parameter int ACC_W        = DEF_ACC_W,
  parameter int STARTUP_CYC  = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic stdby,
  output logic osc,
  output logic osc_stb,
  output logic active
);

  localparam logic [63:0]      INC_FULL = calc_inc(64'(REF_FREQ_KHZ), 64'(NOM_FREQ_KHZ), ACC_W);
  localparam logic [ACC_W-1:0] INC      = INC_FULL[ACC_W-1:0];
  localparam int               CNT_W    = (STARTUP_CYC > 0) ? $clog2(STARTUP_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STARTUP_CYC);

  if (INC_FULL == 64'd0 || 2 * NOM_FREQ_KHZ > REF_FREQ_KHZ) begin : g_bad_cfg
    $error("osch: unusable frequency configuration (INC=%0d)", INC_FULL);
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             osc_q, osc_d;
  logic             stb_q, stb_d;
  logic             stdby_s;
  logic             done;

  sync_2ff u_stdby_sync (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .d_i    (stdby),
    .q_o    (stdby_s)
  );

  assign done = (cnt_q == CNT_DONE);

  // Standby only clears the accumulator while osc is low, so a high phase
  // always runs to its natural end and no rise can start under standby.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (!done) begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = '0;
    end else if (stdby_s && !osc_q) begin
      acc_d = '0;
    end else begin
      acc_d = acc_q + INC;
    end
    osc_d = acc_d[ACC_W-1];
    stb_d = osc_d & ~osc_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      osc_q <= 1'b0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      osc_q <= osc_d;
      stb_q <= stb_d;
    end
  end

  assign osc     = osc_q;
  assign osc_stb = stb_q;
  assign active  = done & ~stdby_s;

endmodule

// File: tb/tb_osch.sv
// Directed bench for osch: a 25 MHz instance checked cycle by cycle through an
// expected queue, and a default 15.65 MHz instance checked by edge counting.
module tb_osch;

  logic clk = 1'b0;
  logic rst_n;
  logic stdby_a, stdby_b;
  logic osc_a, stb_a, act_a;
  logic osc_b, stb_b, act_b;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  osch #(.NOM_FREQ_KHZ(25000)) dut_a (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .stdby     (stdby_a),
    .osc       (osc_a),
    .osc_stb   (stb_a),
    .active    (act_a)
  );

  osch dut_b (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .stdby     (stdby_b),
    .osc       (osc_b),
    .osc_stb   (stb_b),
    .active    (act_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Entries are {osc_stb, osc, active} expected after successive clock edges.
  task automatic push(input logic stb, input logic o, input logic act);
    exp_q.push_back({stb, o, act});
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s: expected queue empty at step %0d", tag, i);
      end else begin
        check(tag, 32'({stb_a, osc_a, act_a}), 32'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    int   rises_a, rises_b, stbs_b, high_b, stb_bad;
    logic prev_a, prev_b;
    logic found;

    rst_n   = 1'b0;
    stdby_a = 1'b0;
    stdby_b = 1'b0;
    repeat (3) tick();
    check("rst_osc_a",    32'(osc_a), 32'd0);
    check("rst_stb_a",    32'(stb_a), 32'd0);
    check("rst_active_a", 32'(act_a), 32'd0);
    check("rst_osc_b",    32'(osc_b), 32'd0);
    check("rst_active_b", 32'(act_b), 32'd0);

    // Startup: 16 idle samples (release + 15 edges), then running 0,1,1,0,...
    rst_n = 1'b1;
    check("release_active_a", 32'(act_a), 32'd0);
    for (int k = 1; k <= 15; k++) push(1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) push(i % 4 == 1, (i % 4 == 1) || (i % 4 == 2), 1'b1);
    drain("startup_run", 28);

    // Long window: edge counts, strobe alignment and duty.
    rises_a = 0; rises_b = 0; stbs_b = 0; high_b = 0; stb_bad = 0;
    prev_a = osc_a;
    prev_b = osc_b;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (osc_a && !prev_a) rises_a++;
      if (osc_b && !prev_b) rises_b++;
      if (stb_b) stbs_b++;
      if (osc_b) high_b++;
      if (stb_b !== (osc_b & ~prev_b)) stb_bad++;
      if (stb_a !== (osc_a & ~prev_a)) stb_bad++;
      prev_a = osc_a;
      prev_b = osc_b;
    end
    check("rises_a", 32'(rises_a), 32'd2500);
    total++;
    assert (rises_b >= 1564 && rises_b <= 1566) else begin
      bad++;
      $error("FAIL rises_b: got %0d want 1565+/-1", rises_b);
    end
    check("stb_count_b", 32'(stbs_b), 32'(rises_b));
    check("stb_align", 32'(stb_bad), 32'd0);
    total++;
    assert (high_b >= 4990 && high_b <= 5010) else begin
      bad++;
      $error("FAIL duty_b: got %0d high cycles want 5000+/-10", high_b);
    end
    check("active_b_run", 32'(act_b), 32'd1);

    // Reset in the middle of a high phase clears osc immediately.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (osc_a) found = 1'b1;
    end
    check("find_high_a", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_osc_a",    32'(osc_a), 32'd0);
    check("async_rst_stb_a",    32'(stb_a), 32'd0);
    check("async_rst_active_a", 32'(act_a), 32'd0);
    check("async_rst_osc_b",    32'(osc_b), 32'd0);
    tick();
    tick();

    // Restart with stdby toggling during startup; it must not disturb it.
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) push(1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      stdby_a = (k <= 12) && (k == 11 || $urandom_range(0, 1) == 1);
      drain("startup_stdby", 1);
    end

    // Standby raised just before a rise: the high phase still lasts 2 cycles.
    stdby_a = 1'b1;
    push(1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) push(1'b0, 1'b0, 1'b0);
    drain("stdby_enter", 10);

    // Standby exit: active after 2 cycles, first rise 2 cycles later.
    stdby_a = 1'b0;
    push(1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b1);
    push(1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b1, 1'b1);
    drain("stdby_exit", 8);

    // Single-cycle stdby pulse during a high phase.
    stdby_a = 1'b1;
    push(1'b0, 1'b1, 1'b1);
    drain("pulse_high", 1);
    stdby_a = 1'b0;
    push(1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b1);
    push(1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b1, 1'b1);
    drain("pulse_after", 8);

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
